// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// Purpose  : pops words from an upstream synchronous FIFO and sends each one as a
//            UART frame (start, DATA_WIDTH bits LSB first, optional even parity, stop).
// Latency  : 1 LOAD cycle + CLKS_PER_BIT*(DATA_WIDTH+2+PARITY_EN) cycles per frame;
//            back-to-back frames are separated by 2 idle-high cycles (IDLE, LOAD).
// Backpress: reads only from IDLE when enable=1 and the FIFO is not empty, so
//            exactly one pop per frame; an empty FIFO or enable=0 simply holds IDLE.
// Ports    : clk/rst (sync, active-high); enable, fifo_empty, fifo_data in;
//            fifo_rd_en (combinational), tx, tx_busy, frame_done (one-cycle pulse) out.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   // frame_done is registered, so it is raised one count early to land on the last STOP cycle
   localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                  state;
   logic [CW-1:0]           bit_cnt;
   logic [IW-1:0]           bit_idx;
   logic [DATA_WIDTH-1:0]   shreg;
   logic [DATA_WIDTH-1:0]   sh_next;
   logic                    par;
   logic                    bit_end;

   assign bit_end    = (bit_cnt == CNT_LAST);
   assign sh_next    = shreg >> 1;
   assign tx_busy    = (state != IDLE);
   // The read is combinational so the FIFO's registered data is ready at the LOAD edge.
   assign fifo_rd_en = !rst && (state == IDLE) && enable && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tx         <= 1'b1;
         frame_done <= 1'b0;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         par        <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (fifo_rd_en) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               // Only point where fifo_data is sampled; later FIFO writes cannot disturb the frame.
               shreg   <= fifo_data;
               par     <= ^fifo_data;
               bit_cnt <= '0;
               bit_idx <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     bit_idx <= '0;
                     if (PARITY_EN != 0) begin
                        tx    <= par;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + IW'(1);
                     shreg   <= sh_next;
                     tx      <= sh_next[0];
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            PARITY: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  tx      <= 1'b1;
                  state   <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  bit_cnt    <= bit_cnt + CW'(1);
                  frame_done <= (bit_cnt == CNT_DONE);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// Purpose  : scoreboard bench for fifo_uart_tx; instance 0 without parity, instance 1 with parity.
// Latency  : a frame is expected 1 + 4*(10|11) cycles after the read request.
// Backpress: a behavioural registered-output FIFO feeds each instance.
module tb_fifo_uart_tx;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic [7:0] len;
      logic       kill;
   } frame_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s  [2];
   logic       en_s   [2];
   logic       fe_s   [2];
   logic       rd_s   [2];
   logic       tx_s   [2];
   logic       busy_s [2];
   logic       done_s [2];
   logic [7:0] fd_s   [2] = '{default: '0};

   int n_push [2] = '{default: 0};
   int n_pop  [2] = '{default: 0};
   int rdcnt  [2] = '{default: 0};

   logic [7:0] fq    [2][$];
   frame_t     exp_q [2][$];

   int n_checks = 0;
   int n_fail   = 0;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
      .clk(clk), .rst(rst_s[0]), .enable(en_s[0]), .fifo_empty(fe_s[0]),
      .fifo_data(fd_s[0]), .fifo_rd_en(rd_s[0]), .tx(tx_s[0]),
      .tx_busy(busy_s[0]), .frame_done(done_s[0])
   );

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
      .clk(clk), .rst(rst_s[1]), .enable(en_s[1]), .fifo_empty(fe_s[1]),
      .fifo_data(fd_s[1]), .fifo_rd_en(rd_s[1]), .tx(tx_s[1]),
      .tx_busy(busy_s[1]), .frame_done(done_s[1])
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word into the FIFO plus its expected frame on the scoreboard.
   task automatic send(input int g, input logic [7:0] d, input logic p, input int len, input logic kill);
      frame_t f;
      fq[g].push_back(d);
      n_push[g]++;
      f.data = d;
      f.par  = p;
      f.len  = 8'(len);
      f.kill = kill;
      exp_q[g].push_back(f);
   endtask

   task automatic put_only(input int g, input logic [7:0] d);
      fq[g].push_back(d);
      n_push[g]++;
   endtask

   task automatic wait_quiet(input int g, input int maxc);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      while (n < maxc) begin
         @(negedge clk);
         n++;
         if (exp_q[g].size() == 0 && !busy_s[g] && !rd_s[g]) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("quiet%0d", g), int'(ok), 1);
   endtask

   task automatic wait_rd(input int g, input int base, input string name);
      int n;
      n = 0;
      while (rdcnt[g] == base && n < 40) begin
         @(posedge clk);
         n++;
      end
      check(name, int'(rdcnt[g] != base), 1);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_ch
      assign fe_s[g] = (n_push[g] == n_pop[g]);

      // Upstream FIFO: data appears the cycle after the read request.
      always @(posedge clk) begin
         if (rd_s[g] && fq[g].size() > 0) begin
            fd_s[g]  <= fq[g][0];
            void'(fq[g].pop_front());
            n_pop[g] <= n_pop[g] + 1;
         end
      end

      // Monitor: every read starts a frame that is compared cycle by cycle with the scoreboard entry.
      always begin : mon
         frame_t e;
         int     bad_tx, bad_done, bad_busy, nb, k;
         logic   ab, etx;
         @(negedge clk);
         if (!rst_s[g] && rd_s[g]) begin
            rdcnt[g]++;
            check($sformatf("rd%0d_expected", g), int'(exp_q[g].size() != 0), 1);
            if (exp_q[g].size() != 0) begin
               e        = exp_q[g].pop_front();
               bad_tx   = 0;
               bad_done = 0;
               bad_busy = 0;
               ab       = 1'b0;
               nb       = (int'(e.len) - 1) / 4;
               for (int c = 1; c <= int'(e.len); c++) begin
                  @(negedge clk);
                  if (rst_s[g]) begin
                     ab = 1'b1;
                     break;
                  end
                  if (c == 1) begin
                     etx = 1'b1;
                  end else begin
                     k = (c - 2) / 4;
                     if (k == 0)           etx = 1'b0;
                     else if (k <= 8)      etx = e.data[k-1];
                     else if (k == nb - 1) etx = 1'b1;
                     else                  etx = e.par;
                  end
                  if (tx_s[g] !== etx) bad_tx++;
                  if (done_s[g] !== (c == int'(e.len))) bad_done++;
                  if (busy_s[g] !== 1'b1) bad_busy++;
               end
               check($sformatf("frame%0d_%02h_abort", g, e.data), int'(ab), int'(e.kill));
               if (!ab) begin
                  check($sformatf("frame%0d_%02h_tx_bad_cycles", g, e.data), bad_tx, 0);
                  check($sformatf("frame%0d_%02h_done_bad_cycles", g, e.data), bad_done, 0);
                  check($sformatf("frame%0d_%02h_busy_bad_cycles", g, e.data), bad_busy, 0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int base, base1, n, gap, bad;

      // Reset with enable high and non-empty FIFOs: line idle, no reads.
      rst_s[0] = 1'b1;
      rst_s[1] = 1'b1;
      en_s[0]  = 1'b1;
      en_s[1]  = 1'b1;
      send(0, 8'hA5, 1'b0, 41, 1'b0);
      send(1, 8'h5A, 1'b0, 45, 1'b0);   // four ones: even parity bit 0
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            check($sformatf("rst%0d_tx", g), int'(tx_s[g]), 1);
            check($sformatf("rst%0d_rd", g), int'(rd_s[g]), 0);
            check($sformatf("rst%0d_busy", g), int'(busy_s[g]), 0);
         end
      end
      tick();
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      wait_quiet(0, 200);
      wait_quiet(1, 200);
      check("rd_pulses_a5", rdcnt[0], 1);
      check("rd_pulses_5a", rdcnt[1], 1);

      // Empty FIFO with enable high: nothing happens.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (rd_s[0] || busy_s[0] || !tx_s[0]) bad++;
      end
      check("empty_bad_cycles", bad, 0);

      // Back-to-back 0x00 then 0xFF: two idle-high cycles between frames.
      tick();
      base = rdcnt[0];
      send(0, 8'h00, 1'b0, 41, 1'b0);
      send(0, 8'hFF, 1'b0, 41, 1'b0);
      n = 0;
      while (!done_s[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done_seen", int'(done_s[0]), 1);
      gap = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx_s[0]) gap++;
         else break;
      end
      check("b2b_gap_high_cycles", gap, 2);
      wait_quiet(0, 200);
      check("b2b_rd_pulses", rdcnt[0] - base, 2);

      // enable dropped during data bit 3 with two words queued.
      tick();
      base = rdcnt[0];
      send(0, 8'h81, 1'b0, 41, 1'b0);
      put_only(0, 8'h42);
      wait_rd(0, base, "en_drop_rd_seen");
      repeat (19) @(posedge clk);
      #1;
      en_s[0] = 1'b0;
      wait_quiet(0, 200);
      repeat (10) @(negedge clk);
      check("en_drop_rd_pulses", rdcnt[0] - base, 1);
      check("en_drop_fifo_words", n_push[0] - n_pop[0], 1);

      // Reset during data bit 5 on the parity instance, then 0x07 with parity 1.
      tick();
      base1 = rdcnt[1];
      send(1, 8'h3C, 1'b0, 45, 1'b1);
      wait_rd(1, base1, "rst_mid_rd_seen");
      repeat (27) @(posedge clk);
      #1;
      rst_s[1] = 1'b1;
      tick();
      rst_s[1] = 1'b0;
      @(negedge clk);
      check("rst_mid_tx", int'(tx_s[1]), 1);
      check("rst_mid_busy", int'(busy_s[1]), 0);
      tick();
      send(1, 8'h07, 1'b1, 45, 1'b0);
      wait_quiet(1, 300);
      check("rst_mid_rd_pulses", rdcnt[1] - base1, 2);
      check("rst_mid_fifo_empty", n_push[1] - n_pop[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: frame payload width in bits.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2 or more.
REQ-003 The block SHALL have parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: high permits fetching new words from the upstream FIFO.
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: the empty flag of the upstream synchronous FIFO.
REQ-008 The block SHALL have port fifo_data, input, DATA_WIDTH bits: the registered read data of the upstream FIFO.
REQ-009 The block SHALL have port fifo_rd_en, output, 1 bit: read request to the upstream FIFO.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line output, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, START, DATA, PARITY and STOP.
REQ-014 In IDLE, fifo_rd_en SHALL be high combinationally exactly when enable=1 and fifo_empty=0; at that edge the next state SHALL be LOAD.
REQ-015 fifo_rd_en SHALL be low in every state other than IDLE, giving exactly one pop per frame.
REQ-016 The FIFO presents popped data one cycle after the read (registered output), so LOAD SHALL capture fifo_data into the shift register at its single edge and go to START.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-018 DATA SHALL drive DATA_WIDTH bits LSB first, each for CLKS_PER_BIT cycles.
REQ-019 After DATA, the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-020 PARITY SHALL drive the XOR of all data bits (even parity) for CLKS_PER_BIT cycles.
REQ-021 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, and frame_done SHALL be high in the last STOP cycle only; the next state after STOP SHALL be IDLE.
REQ-022 tx SHALL come from a register, with its value changing on the first cycle of each state.
REQ-023 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0 to CLKS_PER_BIT-1, and wrap to 0 on each bit boundary.
REQ-024 The bit index SHALL count 0 to DATA_WIDTH-1.
REQ-025 Frame length SHALL be 1 (LOAD) + CLKS_PER_BIT*(DATA_WIDTH+2+PARITY_EN) cycles from LOAD to the end of STOP.
REQ-026 Back-to-back frames (FIFO non-empty, enable=1) SHALL show exactly 2 idle-high cycles (IDLE, LOAD) between one STOP and the next START.
REQ-027 enable falling mid-frame SHALL NOT abort the frame: the frame completes, then the FSM stays in IDLE.
REQ-028 enable falling in the cycle fifo_rd_en would assert SHALL suppress that read.
REQ-029 fifo_empty is sampled only in IDLE; a change in any other state SHALL have no effect.
REQ-030 A word in transit SHALL be unaffected by new FIFO writes, since fifo_data is sampled only in LOAD.

Reset
REQ-031 While rst=1 at a clock edge: state SHALL be IDLE, tx=1, tx_busy=0, frame_done=0, and all counters and the shift register SHALL be 0.
REQ-032 While rst=1, fifo_rd_en SHALL be 0 regardless of enable and fifo_empty.
REQ-033 Reset asserted mid-frame SHALL abandon the frame: tx=1 from the next cycle, and the popped word is lost with no re-read.
REQ-034 After rst falls, the first fifo_rd_en SHALL come no earlier than the first cycle after reset in which enable=1 and fifo_empty=0.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8 unless stated)
REQ-035 Reset: rst=1 for 2 cycles with enable=1 and fifo_empty=0 -> tx=1, fifo_rd_en=0, tx_busy=0 throughout.
REQ-036 Single word 0xA5, PARITY_EN=0 -> one fifo_rd_en pulse, then tx: 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4; frame_done in the 41st cycle after LOAD; 41 cycles total from LOAD.
REQ-037 Empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_rd_en never high, tx=1, tx_busy=0.
REQ-038 Back-to-back 0x00 then 0xFF -> exactly 2 fifo_rd_en pulses and exactly 2 tx-high cycles between the first STOP end and the second START.
REQ-039 enable dropped during DATA bit 3 with the FIFO holding 2 words -> the current frame finishes intact, no further fifo_rd_en, FIFO still holds 1 word.
REQ-040 rst pulsed during DATA bit 5, then PARITY_EN=1 run with 0x07 -> tx=1 the cycle after rst, FSM in IDLE; the next frame has parity bit 1 and 1+4*11=45 cycles from LOAD.
